// File: rtl/writeback_regfile.sv
// 32 x 128-bit writeback register file with three combinational read ports.
// Each read port bypasses ALUOut from the retiring instruction; the block also counts committed writes.
module writeback_regfile (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb_valid,
    input  logic [24:0]  instructionWB,
    input  logic [127:0] ALUOut,
    input  logic [24:0]  instructionID,
    output logic [127:0] rs1,
    output logic [127:0] rs2,
    output logic [127:0] rs3,
    output logic         fowarded_data,
    output logic [15:0]  retire_count,
    output logic [4:0]   last_rd
);

    logic [127:0] regs_q [32];
    logic [15:0]  retire_count_q, retire_count_d;
    logic [4:0]   last_rd_q, last_rd_d;

    logic       is_nop;
    logic       we;
    logic [4:0] wb_rd;
    logic [4:0] addr1, addr2, addr3;
    logic       byp1, byp2, byp3;

    // Fields the file never decodes; folded into one name so they read as intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{instructionID[24:20], instructionID[4:0], instructionWB[14:5]};

    always_comb begin
        is_nop = (instructionWB[24:23] == 2'b11) && (instructionWB[22:15] == 8'h00);
        we     = wb_valid && !rst && !is_nop;
        wb_rd  = instructionWB[4:0];
        addr1  = instructionID[9:5];
        addr2  = instructionID[14:10];
        addr3  = instructionID[19:15];
    end

    always_comb begin
        byp1          = we && (addr1 == wb_rd);
        byp2          = we && (addr2 == wb_rd);
        byp3          = we && (addr3 == wb_rd);
        rs1           = byp1 ? ALUOut : regs_q[addr1];
        rs2           = byp2 ? ALUOut : regs_q[addr2];
        rs3           = byp3 ? ALUOut : regs_q[addr3];
        fowarded_data = byp1 || byp2 || byp3;
    end

    always_comb begin
        retire_count_d = retire_count_q;
        last_rd_d      = last_rd_q;
        if (we) begin
            retire_count_d = retire_count_q + 16'd1;
            last_rd_d      = wb_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            retire_count_q <= '0;
            last_rd_q      <= '0;
        end else begin
            if (we) begin
                regs_q[wb_rd] <= ALUOut;
            end
            retire_count_q <= retire_count_d;
            last_rd_q      <= last_rd_d;
        end
    end

    assign retire_count = retire_count_q;
    assign last_rd      = last_rd_q;

endmodule
